// File: rtl/mac4_pkg.sv
// Shared widths and FSM state type for the mac4 multiply-accumulate slice.
package mac4_pkg;
    localparam int OPND_W = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/mul4_array.sv
// Combinational 4x4 unsigned array multiplier (sum of shifted partial products).
module mul4_array
    import mac4_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] prod
);
    always_comb begin
        prod = '0;
        for (int i = 0; i < OPND_W; i++) begin
            prod = prod + ({{(PROD_W-OPND_W){1'b0}}, a & {OPND_W{b[i]}}} << i);
        end
    end
endmodule

// File: rtl/mac4_accum.sv
// N_TERMS-term 4-bit dot-product accumulator with valid/ready in and out.
// Define MAC4_SAT_EN to saturate the accumulator instead of wrapping.
module mac4_accum
    import mac4_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] x,
    input  logic [OPND_W-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);
    state_t              state;
    state_t              nxt;
    logic [OPND_W-1:0]   x_r;
    logic [OPND_W-1:0]   y_r;
    logic                p_valid;
    logic [7:0]          cnt;
    logic [ACC_W-1:0]    acc;
    logic                ovf_r;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc_nxt;
    logic                accept;
    logic                last;

    mul4_array u_mul (
        .a    (x_r),
        .b    (y_r),
        .prod (prod)
    );

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == DONE);
    assign result    = acc;
    assign ovf       = ovf_r;
    assign accept    = in_valid && in_ready && !clr;
    assign last      = (cnt == 8'(N_TERMS - 1));

    // Bit ACC_W of sum is the carry out used for both wrap and saturation.
    always_comb begin
        sum = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
`ifdef MAC4_SAT_EN
        acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (accept) nxt = last ? DRAIN : ACCUM;
            ACCUM: if (accept && last) nxt = DRAIN;
            DRAIN: if (!p_valid) nxt = DONE;
            DONE:  if (out_ready) nxt = IDLE;
        endcase
        if (clr) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            y_r     <= '0;
            p_valid <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            ovf_r   <= 1'b0;
        end else if (clr) begin
            p_valid <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            ovf_r   <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                x_r <= x;
                y_r <= y;
                cnt <= cnt + 8'd1;
            end
            if (p_valid) begin
                acc   <= acc_nxt;
                ovf_r <= ovf_r | sum[ACC_W];
            end
            if (state == DONE && out_ready) begin
                acc   <= '0;
                cnt   <= '0;
                ovf_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac4_accum.sv
// Directed self-checking bench for mac4_accum (default, 8-bit/2-term, 1-term).
module tb_mac4_accum;
    logic clk = 0;
    logic rst_n, clr, in_valid, out_ready;
    logic [3:0] x, y;

    logic        a_in_ready, a_out_valid, a_ovf;
    logic [11:0] a_result;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [7:0]  b_result;
    logic        c_in_ready, c_out_valid, c_ovf;
    logic [11:0] c_result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac4_accum u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .x(x), .y(y),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .result(a_result), .ovf(a_ovf)
    );

    mac4_accum #(.N_TERMS(2), .ACC_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .x(x), .y(y),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .result(b_result), .ovf(b_ovf)
    );

    mac4_accum #(.N_TERMS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(c_in_ready),
        .x(x), .y(y),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .result(c_result), .ovf(c_ovf)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        in_valid = 0;
        clr = 1;
        step();
        clr = 0;
    endtask

    task automatic send(input logic [3:0] xv, input logic [3:0] yv);
        x = xv;
        y = yv;
        in_valid = 1;
        step();
        in_valid = 0;
    endtask

    logic [3:0] bx [4] = '{4'd3, 4'd15, 4'd0, 4'd7};
    logic [3:0] by [4] = '{4'd5, 4'd15, 4'd9, 4'd2};

    initial begin
        rst_n = 0; clr = 0; in_valid = 0; out_ready = 0; x = 0; y = 0;
        #12;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_result", a_result, 0);
        check("rst_ovf", a_ovf, 0);
        rst_n = 1;
        step();

        // basic dot product
        do_clr();
        for (int i = 0; i < 4; i++) begin
            check("basic_ready_pre", a_in_ready, 1);
            send(bx[i], by[i]);
        end
        check("basic_ready_k", a_in_ready, 0);
        check("basic_valid_k", a_out_valid, 0);
        step();
        check("basic_valid_k1", a_out_valid, 0);
        check("basic_ready_k1", a_in_ready, 0);
        step();
        check("basic_valid_k2", a_out_valid, 1);
        check("basic_result", a_result, 254);
        check("basic_ovf", a_ovf, 0);
        check("basic_ready_done", a_in_ready, 0);
        out_ready = 1;
        step();
        out_ready = 0;
        check("basic_release_valid", a_out_valid, 0);
        check("basic_release_ready", a_in_ready, 1);

        // backpressure
        do_clr();
        for (int i = 0; i < 4; i++) send(bx[i], by[i]);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", a_out_valid, 1);
            check("bp_result", a_result, 254);
            check("bp_ready", a_in_ready, 0);
            step();
        end
        out_ready = 1;
        step();
        out_ready = 0;
        check("bp_idle_ready", a_in_ready, 1);
        check("bp_idle_valid", a_out_valid, 0);
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
        step();
        step();
        check("bp_next_valid", a_out_valid, 1);
        check("bp_next_result", a_result, 4);

        // overflow on 8-bit, 2-term instance
        do_clr();
        send(4'd15, 4'd15);
        send(4'd15, 4'd15);
        step();
        step();
        check("ovf_valid", b_out_valid, 1);
`ifdef MAC4_SAT_EN
        check("ovf_result", b_result, 255);
`else
        check("ovf_result", b_result, 194);
`endif
        check("ovf_flag", b_ovf, 1);

        // clear aborts in-flight work
        do_clr();
        send(4'd15, 4'd15);
        send(4'd2, 4'd2);
        x = 4'd1; y = 4'd1; in_valid = 1; clr = 1;
        step();
        clr = 0; in_valid = 0;
        check("clr_ready", a_in_ready, 1);
        check("clr_result", a_result, 0);
        step();
        check("clr_result_hold", a_result, 0);
        for (int i = 0; i < 4; i++) send(4'd4, 4'd4);
        step();
        step();
        check("clr_valid", a_out_valid, 1);
        check("clr_sum", a_result, 64);
        check("clr_ovf", a_ovf, 0);

        // asynchronous reset mid-run
        do_clr();
        send(4'd1, 4'd1);
        send(4'd1, 4'd1);
        send(4'd1, 4'd1);
        check("arst_pre_ready", a_in_ready, 1);
        #2 rst_n = 0;
        #1;
        check("arst_ready", a_in_ready, 1);
        check("arst_valid", a_out_valid, 0);
        check("arst_result", a_result, 0);
        check("arst_ovf", a_ovf, 0);
        #2 rst_n = 1;
        step();
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
        step();
        step();
        check("arst_after_valid", a_out_valid, 1);
        check("arst_after_result", a_result, 4);

        // single-term instance
        do_clr();
        send(4'd9, 4'd11);
        check("single_ready_k", c_in_ready, 0);
        check("single_valid_k", c_out_valid, 0);
        step();
        check("single_valid_k1", c_out_valid, 0);
        step();
        check("single_valid_k2", c_out_valid, 1);
        check("single_result", c_result, 99);
        check("single_ovf", c_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mac4_accum.md
Name: mac4_accum

Overview:
- Sequential multiply-accumulate stage directly downstream of the combinational 4x4 unsigned array multiplier.
- Accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each pair.
- Adds each registered 8-bit product into an accumulator.
- Emits the N_TERMS-term dot product over a second valid/ready handshake.

Parameters:
- N_TERMS, 4, number of operand pairs per result; legal range 1..255.
- ACC_W, 12, accumulator/result width; legal range 8..16.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort/clear.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair.
- x  input  4  unsigned operand.
- y  input  4  unsigned operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  ACC_W  accumulated sum.
- ovf  output  1  sticky overflow, valid with result.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, ovf=0, cnt=0, operand regs=0, p_valid=0.
- Input accept occurs when in_valid&&in_ready at a rising edge.
  - x,y latch into x_r,y_r.
  - p_valid=1.
  - cnt increments.
- Product stage: prod = x_r*y_r, 8 bits, combinational through the sub-module.
  - When p_valid=1, acc <= acc + zero-extended prod at the next edge.
  - p_valid clears unless a new pair is accepted on the same edge.
- Throughput: one pair per cycle while in ACCUM.
- Latency: last pair accepted at edge k -> out_valid=1 after edge k+2.
- States:
  - IDLE: in_ready=1. Accept -> ACCUM, or -> DRAIN if N_TERMS==1.
  - ACCUM: in_ready=1. Accept making cnt==N_TERMS -> DRAIN.
  - DRAIN: in_ready=0. Final product added at next edge -> DONE.
  - DONE: out_valid=1, result=acc, in_ready=0.
    - out_ready=1 -> acc=0, cnt=0, ovf=0 -> IDLE.
    - Otherwise result and ovf are held stable.
- Arithmetic: acc wraps modulo 2^ACC_W. ovf sets sticky on any carry out of bit ACC_W-1.
- clr=1 at an edge, in any state:
  - acc=0, cnt=0, p_valid=0, ovf=0, state=IDLE.
  - Any in-flight or simultaneously offered pair is discarded.
  - clr has priority over both handshakes.
- Reset mid-operation: all state is discarded immediately and asynchronously; no partial result is emitted.
- Zero operands count as terms.
- in_valid while in_ready=0 is ignored; x,y need not be held.

Optional Feature:
- Macro: MAC4_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_W-1 instead of wrapping; ovf still sets on the first saturation.
- Undefined: modulo wrap as above.

Decomposition:
- Package mac4_pkg:
  - OPND_W=4, PROD_W=8.
  - state enum {IDLE, ACCUM, DRAIN, DONE}.
- One sub-module: mul4_array, a combinational 4x4 unsigned array multiplier (8-bit product), instantiated once on x_r,y_r.

Test Plan:
- Basic dot product: defaults; pairs (3,5),(15,15),(0,9),(7,2), back-to-back.
  - Required: out_valid 2 cycles after the 4th accept, result=254, ovf=0.
  - Required: in_ready=0 from the 4th accept until the output handshake.
- Backpressure: same stimulus with out_ready=0 for 5 cycles.
  - Required: result=254 held stable, in_ready=0.
  - Required: release -> IDLE next cycle, following run starts from acc=0.
- Overflow: ACC_W=8, N_TERMS=2, pairs (15,15),(15,15).
  - Macro undefined: result=194, ovf=1.
  - MAC4_SAT_EN defined: result=255, ovf=1.
- Clear: accept (15,15),(2,2); assert clr on the edge offering (1,1); then feed (4,4)x4.
  - Required: result=64, aborted terms absent.
- Reset mid-run: rst_n low asynchronously between edges while in ACCUM.
  - Required: outputs are at reset values immediately.
  - Required: after release, (1,1)x4 -> result=4.
- Single term: N_TERMS=1, pair (9,11).
  - Required: out_valid 2 cycles after accept, result=99.
